// File: rtl/deu_gpr_scb_rf.sv
// GPR file with per-register busy scoreboard, write-to-read bypass
// and a registered busy count for decode operand readiness.
module deu_gpr_scb_rf #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 3,
    parameter int NUM_ALLOC  = 2,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_RD-1:0]                   re_i,
    input  logic [NUM_RD-1:0][AW-1:0]           raddr_i,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_RD-1:0]                   rrdy_o,
    input  logic [NUM_WR-1:0]                   we_i,
    input  logic [NUM_WR-1:0][AW-1:0]           waddr_i,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_ALLOC-1:0]                alloc_v_i,
    input  logic [NUM_ALLOC-1:0][AW-1:0]        alloc_addr_i,
    input  logic                                flush_i,
    output logic [AW:0]                         busy_cnt_o
);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t               regs_q [1:NUM_REGS-1];
    word_t               regs_d [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:1] busy_d;
    logic [AW:0]         cnt_q;
    logic [AW:0]         cnt_d;

    always_comb begin
        word_t stored;
        word_t fwd;
        logic  busy;
        logic  hit;
        rdata_o = '0;
        rrdy_o  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            stored = '0;
            fwd    = '0;
            busy   = 1'b0;
            hit    = 1'b0;
            // Address 0 matches no storage slot: reads 0, never busy
            for (int r = 1; r < NUM_REGS; r++) begin
                if (raddr_i[p] == AW'(r)) begin
                    stored = regs_q[r];
                    busy   = busy_q[r];
                end
            end
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (we_i[w] && waddr_i[w] == raddr_i[p] &&
                        raddr_i[p] != '0) begin
                        hit = 1'b1;
                        fwd = wdata_i[w];
                    end
                end
            end
            rdata_o[p] = re_i[p] ? (hit ? fwd : stored) : '0;
            rrdy_o[p]  = re_i[p] & (~busy | hit);
        end
    end

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        cnt_d  = '0;
        // Ascending port order lets the highest-indexed writer win
        for (int w = 0; w < NUM_WR; w++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (we_i[w] && waddr_i[w] == AW'(r)) begin
                    regs_d[r] = wdata_i[w];
                    busy_d[r] = 1'b0;
                end
            end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (alloc_v_i[a] && alloc_addr_i[a] == AW'(r)) begin
                    busy_d[r] = 1'b1;
                end
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt_o = cnt_q;

endmodule

// File: tb/tb_deu_gpr_scb_rf.sv
// Bench for deu_gpr_scb_rf: bypass and non-bypass builds side by side
// against an array-based model of registers and busy bits.
module tb_deu_gpr_scb_rf;

    localparam int DW = 64;
    localparam int NR = 32;
    localparam int AW = 5;

    logic                   clk;
    logic                   rst;
    logic [3:0]             re;
    logic [3:0][AW-1:0]     raddr;
    logic [2:0]             we;
    logic [2:0][AW-1:0]     waddr;
    logic [2:0][DW-1:0]     wdata;
    logic [1:0]             av;
    logic [1:0][AW-1:0]     aa;
    logic                   flush;

    logic [3:0][DW-1:0]     rdata1, rdata0;
    logic [3:0]             rrdy1, rrdy0;
    logic [AW:0]            cnt1, cnt0;

    deu_gpr_scb_rf #(.BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .re_i(re), .raddr_i(raddr),
        .rdata_o(rdata1), .rrdy_o(rrdy1), .we_i(we), .waddr_i(waddr),
        .wdata_i(wdata), .alloc_v_i(av), .alloc_addr_i(aa),
        .flush_i(flush), .busy_cnt_o(cnt1)
    );

    deu_gpr_scb_rf #(.BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .re_i(re), .raddr_i(raddr),
        .rdata_o(rdata0), .rrdy_o(rrdy0), .we_i(we), .waddr_i(waddr),
        .wdata_i(wdata), .alloc_v_i(av), .alloc_addr_i(aa),
        .flush_i(flush), .busy_cnt_o(cnt0)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    logic [DW-1:0] m_regs [NR];
    bit          m_busy [NR];
    int          m_cnt;

    task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        rst   = 1'b0;
        re    = '0;
        raddr = '0;
        we    = '0;
        waddr = '0;
        wdata = '0;
        av    = '0;
        aa    = '0;
        flush = 1'b0;
    endtask

    function automatic void exp_read(int p, bit byp,
                                     output logic [DW-1:0] d,
                                     output logic r);
        int a;
        bit hit;
        logic [DW-1:0] f;
        a   = int'(raddr[p]);
        hit = 1'b0;
        f   = '0;
        if (!re[p]) begin
            d = '0;
            r = 1'b0;
        end else if (a == 0) begin
            d = '0;
            r = 1'b1;
        end else begin
            for (int w = 0; w < 3; w++)
                if (byp && we[w] && int'(waddr[w]) == a) begin
                    hit = 1'b1;
                    f   = wdata[w];
                end
            d = hit ? f : m_regs[a];
            r = !m_busy[a] || hit;
        end
    endfunction

    task automatic model_step();
        bit wr [NR];
        bit al [NR];
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int r = 0; r < NR; r++) begin
                wr[r] = 1'b0;
                al[r] = 1'b0;
            end
            for (int w = 0; w < 3; w++)
                if (we[w] && waddr[w] != 0) begin
                    m_regs[waddr[w]] = wdata[w];
                    wr[waddr[w]] = 1'b1;
                end
            for (int k = 0; k < 2; k++)
                if (av[k] && aa[k] != 0) al[aa[k]] = 1'b1;
            for (int r = 1; r < NR; r++) begin
                if (flush)      m_busy[r] = 1'b0;
                else if (al[r]) m_busy[r] = 1'b1;
                else if (wr[r]) m_busy[r] = 1'b0;
            end
        end
        m_cnt = 0;
        for (int r = 1; r < NR; r++) m_cnt += int'(m_busy[r]);
    endtask

    task automatic cyc();
        logic [DW-1:0] d;
        logic r;
        #1;
        for (int p = 0; p < 4; p++) begin
            exp_read(p, 1'b1, d, r);
            chk($sformatf("b1_rd%0d", p), rdata1[p], d);
            chk($sformatf("b1_rdy%0d", p), {63'd0, rrdy1[p]}, {63'd0, r});
            exp_read(p, 1'b0, d, r);
            chk($sformatf("b0_rd%0d", p), rdata0[p], d);
            chk($sformatf("b0_rdy%0d", p), {63'd0, rrdy0[p]}, {63'd0, r});
        end
        model_step();
        @(posedge clk);
        #1;
        chk("b1_cnt", DW'(cnt1), DW'(m_cnt));
        chk("b0_cnt", DW'(cnt0), DW'(m_cnt));
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        m_cnt = 0;
        clr();
        rst = 1'b1;
        cyc();

        clr();
        re = 4'b0011; raddr[0] = 5; raddr[1] = 0;
        #1;
        chk("r5_rst", rdata1[0], 0);
        chk("r5_rdy", DW'(rrdy1[0]), 1);
        chk("r0_rdy", DW'(rrdy1[1]), 1);
        cyc();

        clr();
        we = 3'b111; waddr = {5'd7, 5'd7, 5'd7};
        wdata[0] = 64'h11; wdata[1] = 64'h22; wdata[2] = 64'h33;
        re[0] = 1'b1; raddr[0] = 7;
        #1;
        chk("r7_byp", rdata1[0], 64'h33);
        chk("r7_nobyp", rdata0[0], 64'h0);
        cyc();
        clr();
        re[0] = 1'b1; raddr[0] = 7;
        #1;
        chk("r7_stored", rdata0[0], 64'h33);
        cyc();

        clr();
        av = 2'b11; aa[0] = 3; aa[1] = 9;
        cyc();
        chk("cnt_alloc2", DW'(cnt1), 2);
        clr();
        re[0] = 1'b1; raddr[0] = 3;
        #1;
        chk("r3_busy", DW'(rrdy1[0]), 0);
        cyc();
        clr();
        re[0] = 1'b1; raddr[0] = 3;
        we[0] = 1'b1; waddr[0] = 3; wdata[0] = 64'hAB;
        #1;
        chk("r3_wb_byp_rdy", DW'(rrdy1[0]), 1);
        chk("r3_wb_nobyp_rdy", DW'(rrdy0[0]), 0);
        cyc();
        chk("cnt_wb", DW'(cnt1), 1);

        clr();
        av[0] = 1'b1; aa[0] = 4;
        we[1] = 1'b1; waddr[1] = 4; wdata[1] = 64'h55;
        cyc();
        chk("cnt_alloc_wr", DW'(cnt1), 2);
        clr();
        we[2] = 1'b1; waddr[2] = 0; wdata[2] = 64'hFF;
        re[1] = 1'b1; raddr[1] = 0;
        cyc();
        clr();
        re = 4'b0011; raddr[0] = 4; raddr[1] = 0;
        #1;
        chk("r4_data", rdata0[0], 64'h55);
        chk("r4_busy", DW'(rrdy1[0]), 0);
        chk("r0_ignored", rdata1[1], 0);
        cyc();

        foreach (aa[k]) aa[k] = '0;
        for (int i = 0; i < 3; i++) begin
            clr();
            av[0] = 1'b1;
            aa[0] = (i == 0) ? 5'd2 : (i == 1) ? 5'd6 : 5'd8;
            cyc();
        end
        clr();
        flush = 1'b1;
        av[1] = 1'b1; aa[1] = 10;
        we[0] = 1'b1; waddr[0] = 6; wdata[0] = 64'h77;
        cyc();
        chk("cnt_flush", DW'(cnt1), 0);
        clr();
        re = 4'b0011; raddr[0] = 6; raddr[1] = 10;
        #1;
        chk("r6_flush_wr", rdata0[0], 64'h77);
        chk("r10_not_busy", DW'(rrdy1[1]), 1);
        cyc();

        clr();
        rst = 1'b1;
        we[0] = 1'b1; waddr[0] = 12; wdata[0] = 64'hDEAD;
        av[0] = 1'b1; aa[0] = 12;
        cyc();
        clr();
        re[0] = 1'b1; raddr[0] = 12;
        #1;
        chk("r12_rst_data", rdata0[0], 0);
        chk("r12_rst_rdy", DW'(rrdy0[0]), 1);
        cyc();

        for (int i = 0; i < 400; i++) begin
            clr();
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < 4; p++) begin
                re[p]    = 1'($urandom_range(0, 1));
                raddr[p] = AW'($urandom_range(0, 15));
            end
            for (int w = 0; w < 3; w++) begin
                we[w]    = 1'($urandom_range(0, 1));
                waddr[w] = AW'($urandom_range(0, 15));
                wdata[w] = {$urandom, $urandom};
            end
            for (int k = 0; k < 2; k++) begin
                av[k] = ($urandom_range(0, 2) == 0);
                aa[k] = AW'($urandom_range(0, 15));
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
